// File: rtl/id_stage_if.sv
// Bundle of decode-stage pipeline signals: the fetch->decode handshake, the decode->EX
// handshake and bundle, the branch redirect back to fetch, and the forwarding/writeback
// buses feeding the operand bypass network.
interface id_stage_if #(
  parameter int DS2ES_W = 150
);
  logic               fs2ds_valid;
  logic [63:0]        fs2ds_bus;
  logic               ds_allowin;
  logic [32:0]        br_zip;
  logic               es_allowin;
  logic               ds2es_valid;
  logic [DS2ES_W-1:0] ds2es_bus;
  logic [38:0]        es_fwd;
  logic [38:0]        ms_fwd;
  logic [37:0]        ws_rf_zip;

  // Pipeline environment side: drives fetch, EX backpressure and the forwarding buses.
  modport master (
    output fs2ds_valid, fs2ds_bus, es_allowin, es_fwd, ms_fwd, ws_rf_zip,
    input  ds_allowin, br_zip, ds2es_valid, ds2es_bus
  );

  // Decode stage side.
  modport slave (
    input  fs2ds_valid, fs2ds_bus, es_allowin, es_fwd, ms_fwd, ws_rf_zip,
    output ds_allowin, br_zip, ds2es_valid, ds2es_bus
  );
endinterface

// File: rtl/id_stage.sv
// LoongArch32 decode stage: latches {inst, pc} from fetch, decodes it, reads the internal
// 32x32 register file (written by WB), bypasses EX/MEM/WB results, stalls on load-use,
// resolves branches/jumps and hands the decoded bundle to EX.
//
// Handshake: a stage transfers on a clock edge when its valid and the downstream allowin
// are both high. ds_allowin = ~ds_valid | (ds_ready_go & es_allowin); ds2es_valid is
// ds_valid qualified by ds_ready_go; the only reason to hold is a load-use hazard.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h1BFF_FFFC,
  parameter int          DS2ES_W  = 150
) (
  input logic       clk,
  input logic       resetn,
  id_stage_if.slave pipe_io
);

  // Stage state
  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_inst_q,  ds_inst_d;
  logic [31:0] ds_pc_q,    ds_pc_d;
  logic [31:0] rf_q [32];

  // Forwarding / writeback fields
  logic        es_v, es_is_load, ms_v, ws_we;
  logic [4:0]  es_addr, ms_addr, ws_addr;
  logic [31:0] es_data, ms_data, ws_data;
  logic        unused_ms_is_load;

  assign es_v       = pipe_io.es_fwd[38];
  assign es_is_load = pipe_io.es_fwd[37];
  assign es_addr    = pipe_io.es_fwd[36:32];
  assign es_data    = pipe_io.es_fwd[31:0];
  assign ms_v       = pipe_io.ms_fwd[38];
  assign ms_addr    = pipe_io.ms_fwd[36:32];
  assign ms_data    = pipe_io.ms_fwd[31:0];
  assign ws_we      = pipe_io.ws_rf_zip[37];
  assign ws_addr    = pipe_io.ws_rf_zip[36:32];
  assign ws_data    = pipe_io.ws_rf_zip[31:0];
  // MEM results are already available, so its load flag carries no hazard information.
  assign unused_ms_is_load = pipe_io.ms_fwd[37];

  // Instruction fields
  logic [4:0] rd, rj, rk;
  assign rd = ds_inst_q[4:0];
  assign rj = ds_inst_q[9:5];
  assign rk = ds_inst_q[14:10];

  // Opcode match
  logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
  logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
  logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;

  assign inst_add   = ds_inst_q[31:15] == 17'h00020;
  assign inst_sub   = ds_inst_q[31:15] == 17'h00022;
  assign inst_slt   = ds_inst_q[31:15] == 17'h00024;
  assign inst_sltu  = ds_inst_q[31:15] == 17'h00025;
  assign inst_nor   = ds_inst_q[31:15] == 17'h00028;
  assign inst_and   = ds_inst_q[31:15] == 17'h00029;
  assign inst_or    = ds_inst_q[31:15] == 17'h0002A;
  assign inst_xor   = ds_inst_q[31:15] == 17'h0002B;
  assign inst_slli  = ds_inst_q[31:15] == 17'h00081;
  assign inst_srli  = ds_inst_q[31:15] == 17'h00089;
  assign inst_srai  = ds_inst_q[31:15] == 17'h00091;
  assign inst_addi  = ds_inst_q[31:22] == 10'h00A;
  assign inst_ld    = ds_inst_q[31:22] == 10'h0A2;
  assign inst_st    = ds_inst_q[31:22] == 10'h0A6;
  assign inst_lu12i = ds_inst_q[31:25] == 7'h0A;
  assign inst_jirl  = ds_inst_q[31:26] == 6'h13;
  assign inst_b     = ds_inst_q[31:26] == 6'h14;
  assign inst_bl    = ds_inst_q[31:26] == 6'h15;
  assign inst_beq   = ds_inst_q[31:26] == 6'h16;
  assign inst_bne   = ds_inst_q[31:26] == 6'h17;

  logic is_rtype, is_shift;
  assign is_rtype = inst_add | inst_sub | inst_slt | inst_sltu |
                    inst_and | inst_or  | inst_nor | inst_xor;
  assign is_shift = inst_slli | inst_srli | inst_srai;

  // Immediates
  logic [31:0] imm_si12, imm_ui5, imm_si20, offs16, offs26;
  assign imm_si12 = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
  assign imm_ui5  = {27'd0, ds_inst_q[14:10]};
  assign imm_si20 = {ds_inst_q[24:5], 12'd0};
  assign offs16   = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};
  assign offs26   = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};

  // Control decode; unknown opcodes fall through as a NOP with no side effects.
  logic [11:0] alu_op;
  logic        src1_is_pc, src2_is_imm, res_from_mem, mem_we, rf_we;
  logic [4:0]  dest;
  logic [31:0] imm;
  logic        use_rj, use_rkd, rkd_is_rd;

  assign alu_op = {inst_lu12i, inst_srai, inst_srli, inst_slli, inst_xor, inst_or,
                   inst_nor, inst_and, inst_sltu, inst_slt, inst_sub,
                   inst_add | inst_addi | inst_ld | inst_st | inst_bl | inst_jirl};
  assign src1_is_pc   = inst_bl | inst_jirl;
  assign src2_is_imm  = is_shift | inst_addi | inst_lu12i | inst_ld | inst_st |
                        inst_bl | inst_jirl;
  assign res_from_mem = inst_ld;
  assign mem_we       = inst_st;
  assign dest         = inst_bl ? 5'd1 : rd;
  assign rf_we        = (is_rtype | is_shift | inst_addi | inst_lu12i | inst_ld |
                         inst_bl | inst_jirl) & (dest != 5'd0);
  assign rkd_is_rd    = inst_st | inst_beq | inst_bne;
  assign use_rj       = is_rtype | is_shift | inst_addi | inst_ld | inst_st |
                        inst_jirl | inst_beq | inst_bne;
  assign use_rkd      = is_rtype | rkd_is_rd;

  // Immediate select; link instructions carry 4 so EX computes pc+4.
  always_comb begin
    imm = 32'd0;
    if (is_shift)                              imm = imm_ui5;
    if (inst_addi | inst_ld | inst_st)         imm = imm_si12;
    if (inst_lu12i)                            imm = imm_si20;
    if (inst_b)                                imm = offs26;
    if (inst_beq | inst_bne)                   imm = offs16;
    if (inst_bl | inst_jirl)                   imm = 32'd4;
  end

  // Operand read with bypass, youngest producer wins; r0 never matches.
  function automatic logic [31:0] bypass(
    input logic [4:0]  addr,   input logic [31:0] rf_val,
    input logic        e_v,    input logic [4:0]  e_a,  input logic [31:0] e_d,
    input logic        m_v,    input logic [4:0]  m_a,  input logic [31:0] m_d,
    input logic        w_v,    input logic [4:0]  w_a,  input logic [31:0] w_d);
    logic [31:0] v;
    v = rf_val;
    if (w_v && w_a != 5'd0 && w_a == addr) v = w_d;
    if (m_v && m_a != 5'd0 && m_a == addr) v = m_d;
    if (e_v && e_a != 5'd0 && e_a == addr) v = e_d;
    return v;
  endfunction

  logic [4:0]  raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, rj_val, rkd_val;
  assign raddr2    = rkd_is_rd ? rd : rk;
  assign rf_rdata1 = (rj == 5'd0)     ? 32'd0 : rf_q[rj];
  assign rf_rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf_q[raddr2];
  assign rj_val    = bypass(rj, rf_rdata1, es_v, es_addr, es_data, ms_v, ms_addr, ms_data,
                            ws_we, ws_addr, ws_data);
  assign rkd_val   = bypass(raddr2, rf_rdata2, es_v, es_addr, es_data, ms_v, ms_addr, ms_data,
                            ws_we, ws_addr, ws_data);

  // Load-use hazard: a load in EX cannot forward yet, so hold only if a used source needs it.
  logic load_use, ds_ready_go;
  assign load_use    = es_v & es_is_load & (es_addr != 5'd0) &
                       ((use_rj & (es_addr == rj)) | (use_rkd & (es_addr == raddr2)));
  assign ds_ready_go = ~load_use;

  // Branch resolution on bypassed operands; never redirects while stalled.
  logic        br_eq, br_taken;
  logic [31:0] br_target;
  assign br_eq     = rj_val == rkd_val;
  assign br_taken  = ds_valid_q & ds_ready_go &
                     (inst_b | inst_bl | inst_jirl | (inst_beq & br_eq) | (inst_bne & ~br_eq));
  assign br_target = inst_jirl ? (rj_val + offs16) :
                     (ds_pc_q + ((inst_b | inst_bl) ? offs26 : offs16));

  logic [DS2ES_W-1:0] ds2es_bus_w;
  assign ds2es_bus_w = {alu_op, src1_is_pc, src2_is_imm, res_from_mem, mem_we, rf_we, dest,
                        rj_val, rkd_val, imm, ds_pc_q};

  assign pipe_io.ds_allowin  = ~ds_valid_q | (ds_ready_go & pipe_io.es_allowin);
  assign pipe_io.ds2es_valid = ds_valid_q & ds_ready_go;
  assign pipe_io.ds2es_bus   = ds2es_bus_w;
  assign pipe_io.br_zip      = br_taken ? {1'b1, br_target} : 33'd0;

  // Next latch contents: accept from fetch when allowed, squashing the fall-through slot.
  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_inst_d  = ds_inst_q;
    ds_pc_d    = ds_pc_q;
    if (pipe_io.ds_allowin) begin
      ds_valid_d = pipe_io.fs2ds_valid & ~br_taken;
      ds_inst_d  = pipe_io.fs2ds_bus[63:32];
      ds_pc_d    = pipe_io.fs2ds_bus[31:0];
    end
  end

  // Stage latch with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= 32'd0;
      ds_pc_q    <= RESET_PC;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q  <= ds_inst_d;
      ds_pc_q    <= ds_pc_d;
    end
  end

  // Register file write port from WB; r0 stays hardwired to zero and contents survive reset.
  always_ff @(posedge clk) begin
    if (ws_we && ws_addr != 5'd0) rf_q[ws_addr] <= ws_data;
  end

endmodule
